// File: rtl/viterbi_k3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_k3_pkg
//  Description : Shared constants, FSM encoding and trellis helper functions
//                for the rate-1/2, K=3 Viterbi decoder (g0=7, g1=5).
//  Revision    : 1.0  initial release
// ============================================================================
package viterbi_k3_pkg;

    localparam int         NUM_STATES = 4;
    localparam logic [2:0] G0         = 3'b111;
    localparam logic [2:0] G1         = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } acs_state_t;

    // Encoder output {c0,c1} when input bit u is shifted into state {s1,s0}.
    // The shift register is {u,s1,s0}, so masking with the generator and
    // reducing with XOR yields c0 = u^s1^s0 and c1 = u^s0.
    function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic u);
        logic [2:0] w_reg;
        w_reg = {u, state};
        return {^(w_reg & G0), ^(w_reg & G1)};
    endfunction

    // Hamming distance between two 2-bit symbols (0..2).
    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        return 2'(a[1] ^ b[1]) + 2'(a[0] ^ b[0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/acs_unit.sv
`default_nettype none
// ============================================================================
//  Module      : acs_unit
//  Description : Add-compare-select for one next state. Adds each
//                predecessor metric to its branch metric at PM_W+1 bits and
//                keeps the smaller sum; on a tie the even predecessor wins.
//  Ports       : pm0/pm1  - predecessor path metrics (even / odd)
//                bm0/bm1  - branch metrics for the two transitions
//                pm_new   - selected candidate, one bit wider than a PM
//                dec      - 1 when the odd predecessor was selected
//  Revision    : 1.0  initial release
// ============================================================================
module acs_unit #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W:0]   pm_new,
    output logic            dec
);

    logic [PM_W:0] w_cand0;
    logic [PM_W:0] w_cand1;

    assign w_cand0 = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
    assign w_cand1 = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};

    // Strict compare so that equal candidates keep the even predecessor.
    assign dec    = (w_cand1 < w_cand0);
    assign pm_new = dec ? w_cand1 : w_cand0;

endmodule
`default_nettype wire

// File: rtl/viterbi_acs_k3.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_acs_k3
//  Description : Hard-decision ACS stage of the K=3 Viterbi decoder. Keeps
//                four path metrics, updates them once per accepted symbol
//                and reports per-state survivor decisions plus the best
//                state/metric with one cycle of latency. Frames of FRAME_LEN
//                symbols are bracketed by an IDLE/RUN controller.
//  Ports       : clk, rst (async, active-low), start, sym_in[1:0], sym_valid
//                busy, dec_out[3:0], dec_valid, best_state[1:0],
//                best_pm[PM_W-1:0], sym_count[CNT_W-1:0], frame_done
//  Revision    : 1.0  initial release
// ============================================================================
module viterbi_acs_k3
    import viterbi_k3_pkg::*;
#(
    parameter int PM_W      = 6,
    parameter int INIT_BIAS = 8,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       sym_in,
    input  logic             sym_valid,
    output logic             busy,
    output logic [3:0]       dec_out,
    output logic             dec_valid,
    output logic [1:0]       best_state,
    output logic [PM_W-1:0]  best_pm,
    output logic [CNT_W-1:0] sym_count,
    output logic             frame_done
);

    localparam logic [PM_W-1:0]  c_init_bias = PM_W'(INIT_BIAS);
    localparam logic [PM_W:0]    c_half      = (PM_W+1)'(2 ** (PM_W - 1));
    localparam logic [CNT_W-1:0] c_frame_len = CNT_W'(FRAME_LEN);

    acs_state_t            r_state;
    acs_state_t            w_state_nxt;
    logic [PM_W-1:0]       r_pm       [NUM_STATES];
    logic [PM_W-1:0]       w_src_pm   [NUM_STATES];
    logic [PM_W:0]         w_acs_pm   [NUM_STATES];
    logic [PM_W-1:0]       w_new_pm   [NUM_STATES];
    logic [NUM_STATES-1:0] w_dec;
    logic                  w_norm;
    logic [1:0]            w_best_state;
    logic [PM_W-1:0]       w_best_pm;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_done_nxt;
    logic [CNT_W-1:0]      w_count_nxt;

    logic [3:0]            r_dec_out;
    logic                  r_dec_valid;
    logic [1:0]            r_best_state;
    logic [PM_W-1:0]       r_best_pm;
    logic [CNT_W-1:0]      r_sym_count;
    logic                  r_frame_done;

    // ------------------------------------------------------------------
    // Frame control
    // ------------------------------------------------------------------
    // Once the last symbol of a frame is in, the frame is closed in the
    // following cycle, so further symbols are refused while w_full holds.
    assign w_full   = (r_sym_count == c_frame_len);
    assign w_accept = sym_valid && (start || ((r_state == ST_RUN) && !w_full));

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A restart takes priority over closing the frame.
                if (!start && w_full) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_count_nxt = r_sym_count;
        if (start) begin
            w_count_nxt = '0;
        end
        if (w_accept) begin
            w_count_nxt = w_count_nxt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Add-compare-select
    // ------------------------------------------------------------------
    // A start in the same cycle as a symbol must see the initial metrics,
    // so the ACS sources are swapped to the init values while start is high.
    always_comb begin
        for (int i = 0; i < NUM_STATES; i++) begin
            w_src_pm[i] = start ? ((i == 0) ? '0 : c_init_bias) : r_pm[i];
        end
    end

    for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
        // Next state {u,s1} is reached from {s1,0} and {s1,1}.
        localparam logic [1:0] c_ns = 2'(ns);
        localparam logic [1:0] c_p0 = {c_ns[0], 1'b0};
        localparam logic [1:0] c_p1 = {c_ns[0], 1'b1};

        logic [1:0] w_bm0;
        logic [1:0] w_bm1;

        assign w_bm0 = hamming2(sym_in, exp_sym(c_p0, c_ns[1]));
        assign w_bm1 = hamming2(sym_in, exp_sym(c_p1, c_ns[1]));

        acs_unit #(
            .PM_W (PM_W)
        ) u_acs (
            .pm0    (w_src_pm[c_p0]),
            .pm1    (w_src_pm[c_p1]),
            .bm0    (w_bm0),
            .bm1    (w_bm1),
            .pm_new (w_acs_pm[ns]),
            .dec    (w_dec[ns])
        );
    end

    // Metrics only matter relative to each other, so when every one of them
    // has reached the upper half the common offset is removed. The spread of
    // the four metrics stays small, which keeps the result inside PM_W bits.
    always_comb begin
        w_norm = 1'b1;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (w_acs_pm[i] < c_half) begin
                w_norm = 1'b0;
            end
        end
        for (int i = 0; i < NUM_STATES; i++) begin
            w_new_pm[i] = PM_W'(w_norm ? (w_acs_pm[i] - c_half) : w_acs_pm[i]);
        end
    end

    // Ascending scan with strict compare: lowest index wins ties.
    always_comb begin
        w_best_state = '0;
        w_best_pm    = w_new_pm[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (w_new_pm[i] < w_best_pm) begin
                w_best_pm    = w_new_pm[i];
                w_best_state = 2'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_dec_out    <= '0;
            r_dec_valid  <= 1'b0;
            r_best_state <= '0;
            r_best_pm    <= '0;
            r_sym_count  <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < NUM_STATES; i++) begin
                r_pm[i] <= (i == 0) ? '0 : c_init_bias;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_dec_valid  <= w_accept;
            r_frame_done <= w_done_nxt;
            r_sym_count  <= w_count_nxt;
            if (w_accept) begin
                r_dec_out    <= w_dec;
                r_best_state <= w_best_state;
                r_best_pm    <= w_best_pm;
                for (int i = 0; i < NUM_STATES; i++) begin
                    r_pm[i] <= w_new_pm[i];
                end
            end else if (start) begin
                for (int i = 0; i < NUM_STATES; i++) begin
                    r_pm[i] <= w_src_pm[i];
                end
            end
        end
    end

    assign busy       = (r_state == ST_RUN);
    assign dec_out    = r_dec_out;
    assign dec_valid  = r_dec_valid;
    assign best_state = r_best_state;
    assign best_pm    = r_best_pm;
    assign sym_count  = r_sym_count;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
